trap_ctrl: RTL and testbench
============================

TRAP_CTRL -- requirements
Module: trap_ctrl

Interface
REQ-001 SHALL have parameters: ECALL_CAUSE, 32'd11, mcause written for ECALL; EBREAK_CAUSE, 32'd3, mcause written for EBREAK.
REQ-002 SHALL have port clk_i  in  1  the single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst_i  in  1  reset, synchronous and active-high.
REQ-004 SHALL have port valid_i  in  1  decode-stage instruction valid.
REQ-005 SHALL have ports is_ecall_i, is_ebreak_i, is_mret_i  in  1 each  decoder flags.
REQ-006 SHALL have port pc_i  in  32  PC of the decode-stage instruction.
REQ-007 SHALL have ports mtvec_i, mepc_i, mstatus_i  in  32 each  current CSR values.
REQ-008 SHALL have ports csr_wr_req_i  in  1, csr_wr_addr_i  in  12, csr_wr_data_i  in  32  instruction CSR write request.
REQ-009 SHALL have port csr_wr_gnt_o  out  1  instruction CSR write accepted this cycle.
REQ-010 SHALL have ports csr_we_o  out  1, csr_waddr_o  out  12, csr_wdata_o  out  32  the single arbitrated CSR write port.
REQ-011 SHALL have ports stall_o  out  1, flush_o  out  1, redirect_valid_o  out  1, redirect_pc_o  out  32.
REQ-012 SHALL have ports busy_o  out  1 (FSM not IDLE), trap_cnt_o  out  16 (traps taken, saturating).

Function
REQ-013 SHALL implement FSM states IDLE, MEPC, MCAUSE, MSTAT_T, MSTAT_R, REDIR.
REQ-014 SHALL, in IDLE with valid_i & (is_ecall_i | is_ebreak_i), capture pc_i and cause, go to MEPC; priority ECALL > EBREAK > MRET when several flags are set.
REQ-015 SHALL, in IDLE with valid_i & is_mret_i (no trap flag), go to MSTAT_R.
REQ-016 SHALL sequence traps MEPC -> MCAUSE -> MSTAT_T -> REDIR -> IDLE, one state per cycle, writing mepc = captured PC, then mcause = captured cause, then mstatus with MPIE<=MIE, MIE<=0, MPP<=2'b11, other bits from mstatus_i.
REQ-017 SHALL sequence MRET as MSTAT_R -> REDIR -> IDLE, writing mstatus with MIE<=MPIE, MPIE<=1, MPP<=2'b11.
REQ-018 SHALL, in REDIR, assert redirect_valid_o and flush_o for exactly one cycle with redirect_pc_o = {mtvec_i[31:2],2'b00} (trap) or mepc_i (MRET), sampled that cycle.
REQ-019 SHALL give latency: trap detected cycle T -> redirect T+4; MRET detected T -> redirect T+2.
REQ-020 SHALL assert stall_o combinationally in the detection cycle and in every non-IDLE state except REDIR-completion is included (stall high through REDIR).
REQ-021 SHALL grant csr_wr_req_i only in IDLE (csr_wr_gnt_o = csr_wr_req_i & IDLE); FSM writes own the port in MEPC/MCAUSE/MSTAT_*; no write in REDIR.
REQ-022 SHALL, on simultaneous instruction CSR write and trap detection in IDLE, grant the instruction write that cycle; trap writes begin next cycle.
REQ-023 SHALL ignore valid_i and all flags while busy_o is high.
REQ-024 SHALL increment trap_cnt_o on entry to MEPC, saturating at 16'hFFFF; MRET does not count.
REQ-025 SHALL drive csr_waddr_o/csr_wdata_o to zero when csr_we_o is low.

Reset
REQ-026 SHALL, with rst_i high at a clock edge, enter IDLE, clear captured PC/cause and trap_cnt_o; all outputs 0 next cycle.
REQ-027 SHALL abandon a sequence on reset mid-operation with no further CSR write and no redirect.

Structure
REQ-028 SHALL place CSR addresses (MSTATUS 12'h300, MTVEC 12'h305, MEPC 12'h341, MCAUSE 12'h342), mstatus bit positions (MIE 3, MPIE 7, MPP 12:11) and the state encoding in the shared package.
REQ-029 SHALL be a single module with no sub-modules.

Verification
REQ-030 SHALL test ECALL at pc_i=32'h0000_0100, mtvec_i=32'h0000_0203, mstatus_i=32'h8 -> writes 0x341=0x100, 0x342=11, 0x300=0x1880; redirect_pc_o=32'h0000_0200 at T+4; trap_cnt_o=1.
REQ-031 SHALL test MRET with mepc_i=32'h0000_0104, mstatus_i=32'h1880 -> write 0x300=0x1888; redirect to 0x104 at T+2; trap_cnt_o unchanged.
REQ-032 SHALL test csr_wr_req_i to 0x305 during MCAUSE -> csr_wr_gnt_o=0 until IDLE, then granted; same-cycle with ECALL detection -> granted, trap writes start T+1.
REQ-033 SHALL test rst_i asserted in MSTAT_T -> no mstatus write, no redirect, busy_o=0, trap_cnt_o=0 next cycle.
REQ-034 SHALL test ECALL and EBREAK flags together -> mcause=11; second ECALL during busy -> ignored.
REQ-035 SHALL test trap_cnt_o preset near saturation via 65536 traps (or forced) -> holds 16'hFFFF.

Source files
------------

// File: rtl/trap_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// trap_ctrl_pkg
// Shared definitions for the trap controller: CSR addresses, mstatus
// field positions, FSM state encoding and mstatus update helpers.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package trap_ctrl_pkg;

  // Machine-mode CSR addresses
  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MTVEC   = 12'h305;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;

  // mstatus bit positions
  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

  // Trap / return sequencer states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_MEPC    = 3'd1,
    ST_MCAUSE  = 3'd2,
    ST_MSTAT_T = 3'd3,
    ST_MSTAT_R = 3'd4,
    ST_REDIR   = 3'd5
  } state_t;

  // mstatus on trap entry: stash MIE in MPIE, disable interrupts, MPP=M
  function automatic logic [31:0] trap_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MPIE] = m[MSTATUS_MIE];
    r[MSTATUS_MIE]  = 1'b0;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

  // mstatus on MRET: restore MIE from MPIE, set MPIE, MPP=M
  function automatic logic [31:0] mret_mstatus(input logic [31:0] m);
    logic [31:0] r;
    r = m;
    r[MSTATUS_MIE]  = m[MSTATUS_MPIE];
    r[MSTATUS_MPIE] = 1'b1;
    r[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/trap_ctrl.sv
// ---------------------------------------------------------------------------
// trap_ctrl
// Sequences ECALL/EBREAK trap entry and MRET return: writes mepc, mcause
// and mstatus one per cycle over a shared CSR write port, then redirects
// the front end. Instruction CSR writes are only granted while idle.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module trap_ctrl
  import trap_ctrl_pkg::*;
#(
  parameter logic [31:0] ECALL_CAUSE  = 32'd11,
  parameter logic [31:0] EBREAK_CAUSE = 32'd3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        valid_i,
  input  logic        is_ecall_i,
  input  logic        is_ebreak_i,
  input  logic        is_mret_i,
  input  logic [31:0] pc_i,
  input  logic [31:0] mtvec_i,
  input  logic [31:0] mepc_i,
  input  logic [31:0] mstatus_i,
  input  logic        csr_wr_req_i,
  input  logic [11:0] csr_wr_addr_i,
  input  logic [31:0] csr_wr_data_i,
  output logic        csr_wr_gnt_o,
  output logic        csr_we_o,
  output logic [11:0] csr_waddr_o,
  output logic [31:0] csr_wdata_o,
  output logic        stall_o,
  output logic        flush_o,
  output logic        redirect_valid_o,
  output logic [31:0] redirect_pc_o,
  output logic        busy_o,
  output logic [15:0] trap_cnt_o
);

  state_t      state;
  state_t      state_nxt;
  logic [31:0] cap_pc;
  logic [31:0] cap_cause;
  logic        cap_is_trap;
  logic [15:0] trap_cnt;

  logic        idle;
  logic        take_trap;
  logic        take_mret;
  logic        fsm_we;
  logic [11:0] fsm_addr;
  logic [31:0] fsm_data;
  logic        redir;

  // mtvec mode bits are discarded: the handler is always direct-mode
  logic        unused_mtvec_mode;
  assign unused_mtvec_mode = ^mtvec_i[1:0];

  // Decode-stage requests are only looked at while idle; ECALL/EBREAK win over MRET
  assign idle      = (state == ST_IDLE);
  assign take_trap = idle & valid_i & (is_ecall_i | is_ebreak_i);
  assign take_mret = idle & valid_i & is_mret_i & ~is_ecall_i & ~is_ebreak_i;

  // State register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture the faulting PC, cause and sequence kind at detection
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cap_pc      <= 32'd0;
      cap_cause   <= 32'd0;
      cap_is_trap <= 1'b0;
    end else if (take_trap) begin
      cap_pc      <= pc_i;
      cap_cause   <= is_ecall_i ? ECALL_CAUSE : EBREAK_CAUSE;
      cap_is_trap <= 1'b1;
    end else if (take_mret) begin
      cap_is_trap <= 1'b0;
    end
  end

  // Saturating count of traps taken (MRET is not counted)
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trap_cnt <= 16'd0;
    end else if (take_trap && (trap_cnt != 16'hFFFF)) begin
      trap_cnt <= trap_cnt + 16'd1;
    end
  end

  // Next-state logic and the FSM's own CSR write / redirect requests
  always_comb begin
    state_nxt = state;
    fsm_we    = 1'b0;
    fsm_addr  = 12'd0;
    fsm_data  = 32'd0;
    redir     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (take_trap) begin
          state_nxt = ST_MEPC;
        end else if (take_mret) begin
          state_nxt = ST_MSTAT_R;
        end
      end
      ST_MEPC: begin
        fsm_we    = 1'b1;
        fsm_addr  = CSR_MEPC;
        fsm_data  = cap_pc;
        state_nxt = ST_MCAUSE;
      end
      ST_MCAUSE: begin
        fsm_we    = 1'b1;
        fsm_addr  = CSR_MCAUSE;
        fsm_data  = cap_cause;
        state_nxt = ST_MSTAT_T;
      end
      ST_MSTAT_T: begin
        fsm_we    = 1'b1;
        fsm_addr  = CSR_MSTATUS;
        fsm_data  = trap_mstatus(mstatus_i);
        state_nxt = ST_REDIR;
      end
      ST_MSTAT_R: begin
        fsm_we    = 1'b1;
        fsm_addr  = CSR_MSTATUS;
        fsm_data  = mret_mstatus(mstatus_i);
        state_nxt = ST_REDIR;
      end
      ST_REDIR: begin
        redir     = 1'b1;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Write-port arbitration. FSM writes and the redirect are masked while
  // reset is high so an abandoned sequence never commits a partial update.
  always_comb begin
    csr_wr_gnt_o = csr_wr_req_i & idle;
    csr_we_o     = 1'b0;
    csr_waddr_o  = 12'd0;
    csr_wdata_o  = 32'd0;
    if (csr_wr_gnt_o) begin
      csr_we_o    = 1'b1;
      csr_waddr_o = csr_wr_addr_i;
      csr_wdata_o = csr_wr_data_i;
    end else if (fsm_we && !rst_i) begin
      csr_we_o    = 1'b1;
      csr_waddr_o = fsm_addr;
      csr_wdata_o = fsm_data;
    end
  end

  // Pipeline control and redirect target
  always_comb begin
    busy_o           = !idle;
    stall_o          = !idle || take_trap || take_mret;
    redirect_valid_o = redir && !rst_i;
    flush_o          = redirect_valid_o;
    redirect_pc_o    = 32'd0;
    if (redirect_valid_o) begin
      redirect_pc_o = cap_is_trap ? {mtvec_i[31:2], 2'b00} : mepc_i;
    end
  end

  assign trap_cnt_o = trap_cnt;

endmodule

`default_nettype wire

// File: tb/tb_trap_ctrl.sv
// ---------------------------------------------------------------------------
// tb_trap_ctrl
// Directed, table-driven bench for trap_ctrl: one table row per clock,
// plus hand-written sequences for counter saturation.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_trap_ctrl;

  typedef struct {
    logic        rst, valid, ecall, ebreak, mret;
    logic [31:0] pc, mtvec, mepc, mstatus;
    logic        req;
    logic [11:0] waddr;
    logic [31:0] wdata;
    logic        e_gnt, e_we;
    logic [11:0] e_waddr;
    logic [31:0] e_wdata;
    logic        e_stall, e_flush, e_rv;
    logic [31:0] e_rpc;
    logic        e_busy;
    logic [15:0] e_cnt;
  } vec_t;

  logic        clk;
  logic        rst, valid, ecall, ebreak, mret;
  logic [31:0] pc, mtvec, mepc, mstatus;
  logic        req;
  logic [11:0] waddr;
  logic [31:0] wdata;
  logic        gnt, we, stall, flush, rv, busy;
  logic [11:0] caddr;
  logic [31:0] cdata, rpc;
  logic [15:0] cnt;

  vec_t vecs[$];
  int   applied;
  int   miscompares;

  trap_ctrl dut (
    .clk_i           (clk),
    .rst_i           (rst),
    .valid_i         (valid),
    .is_ecall_i      (ecall),
    .is_ebreak_i     (ebreak),
    .is_mret_i       (mret),
    .pc_i            (pc),
    .mtvec_i         (mtvec),
    .mepc_i          (mepc),
    .mstatus_i       (mstatus),
    .csr_wr_req_i    (req),
    .csr_wr_addr_i   (waddr),
    .csr_wr_data_i   (wdata),
    .csr_wr_gnt_o    (gnt),
    .csr_we_o        (we),
    .csr_waddr_o     (caddr),
    .csr_wdata_o     (cdata),
    .stall_o         (stall),
    .flush_o         (flush),
    .redirect_valid_o(rv),
    .redirect_pc_o   (rpc),
    .busy_o          (busy),
    .trap_cnt_o      (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Absolute time limit so the run can never hang
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic add(
    input logic rst_v, valid_v, ec, eb, mr,
    input logic [31:0] pc_v, mtvec_v, mepc_v, mst_v,
    input logic req_v, input logic [11:0] wa, input logic [31:0] wd,
    input logic g, w, input logic [11:0] ewa, input logic [31:0] ewd,
    input logic st, fl, rvv, input logic [31:0] erpc,
    input logic bz, input logic [15:0] ecnt);
    vec_t v;
    v.rst = rst_v; v.valid = valid_v; v.ecall = ec; v.ebreak = eb; v.mret = mr;
    v.pc = pc_v; v.mtvec = mtvec_v; v.mepc = mepc_v; v.mstatus = mst_v;
    v.req = req_v; v.waddr = wa; v.wdata = wd;
    v.e_gnt = g; v.e_we = w; v.e_waddr = ewa; v.e_wdata = ewd;
    v.e_stall = st; v.e_flush = fl; v.e_rv = rvv; v.e_rpc = erpc;
    v.e_busy = bz; v.e_cnt = ecnt;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    applied++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h want %h", name, got, want);
    end
  endtask

  task automatic idle_inputs();
    rst = 0; valid = 0; ecall = 0; ebreak = 0; mret = 0;
    pc = 0; mtvec = 32'h0000_0203; mepc = 0; mstatus = 32'h8;
    req = 0; waddr = 0; wdata = 0;
  endtask

  // One ECALL trap with a bounded wait for the redirect, then a count check
  task automatic run_trap(input logic [15:0] exp_cnt, input string name);
    bit seen;
    @(negedge clk);
    valid = 1; ecall = 1; pc = 32'h0000_0700;
    @(negedge clk);
    valid = 0; ecall = 0;
    seen = 0;
    for (int i = 0; i < 8 && !seen; i++) begin
      #1;
      if (rv) seen = 1;
      else @(negedge clk);
    end
    check({name, "_redirect_seen"}, {31'd0, seen}, 32'd1);
    @(negedge clk);
    #1;
    check({name, "_busy"}, {31'd0, busy}, 32'd0);
    check({name, "_cnt"}, {16'd0, cnt}, {16'd0, exp_cnt});
  endtask

  initial begin
    logic [97:0] got, want;
    applied = 0;
    miscompares = 0;
    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);

    // rst v ec eb mr  pc  mtvec  mepc  mstatus  req wa wd | gnt we wa wd  st fl rv rpc  busy cnt
    // reset state
    add(0,0,0,0,0, 32'h0,  32'h0,    32'h0,   32'h0,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     0,0,0,32'h0,    0,16'd0);
    // ECALL at 0x100, mtvec 0x203, mstatus 0x8
    add(0,1,1,0,0, 32'h100,32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,0,0,32'h0,    0,16'd0);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,1,12'h341,32'h100, 1,0,0,32'h0,    1,16'd1);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,1,12'h342,32'd11,  1,0,0,32'h0,    1,16'd1);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,1,12'h300,32'h1880,1,0,0,32'h0,    1,16'd1);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,1,1,32'h200,  1,16'd1);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     0,0,0,32'h0,    0,16'd1);
    // MRET with mepc 0x104, mstatus 0x1880
    add(0,1,0,0,1, 32'h0,  32'h203,  32'h104, 32'h1880, 0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,0,0,32'h0,    0,16'd1);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h104, 32'h1880, 0,12'h0,32'h0,  0,1,12'h300,32'h1888,1,0,0,32'h0,    1,16'd1);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h104, 32'h1880, 0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,1,1,32'h104,  1,16'd1);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h104, 32'h1880, 0,12'h0,32'h0,  0,0,12'h0,32'h0,     0,0,0,32'h0,    0,16'd1);
    // ECALL+EBREAK together -> cause 11; new requests while busy are ignored
    add(0,1,1,1,0, 32'h200,32'h400,  32'h0,   32'h0,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,0,0,32'h0,    0,16'd1);
    add(0,1,0,1,0, 32'h300,32'h400,  32'h0,   32'h0,    0,12'h0,32'h0,  0,1,12'h341,32'h200, 1,0,0,32'h0,    1,16'd2);
    add(0,1,1,0,0, 32'h300,32'h400,  32'h0,   32'h0,    0,12'h0,32'h0,  0,1,12'h342,32'd11,  1,0,0,32'h0,    1,16'd2);
    add(0,1,0,0,1, 32'h300,32'h400,  32'h0,   32'h0,    0,12'h0,32'h0,  0,1,12'h300,32'h1800,1,0,0,32'h0,    1,16'd2);
    add(0,1,1,0,0, 32'h300,32'h400,  32'h0,   32'h0,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,1,1,32'h400,  1,16'd2);
    add(0,0,0,0,0, 32'h0,  32'h400,  32'h0,   32'h0,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     0,0,0,32'h0,    0,16'd2);
    // EBREAK alone -> cause 3, mtvec mode bits dropped
    add(0,1,0,1,0, 32'h40, 32'h1001, 32'h0,   32'h0,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,0,0,32'h0,    0,16'd2);
    add(0,0,0,0,0, 32'h0,  32'h1001, 32'h0,   32'h0,    0,12'h0,32'h0,  0,1,12'h341,32'h40,  1,0,0,32'h0,    1,16'd3);
    add(0,0,0,0,0, 32'h0,  32'h1001, 32'h0,   32'h0,    0,12'h0,32'h0,  0,1,12'h342,32'd3,   1,0,0,32'h0,    1,16'd3);
    add(0,0,0,0,0, 32'h0,  32'h1001, 32'h0,   32'h0,    0,12'h0,32'h0,  0,1,12'h300,32'h1800,1,0,0,32'h0,    1,16'd3);
    add(0,0,0,0,0, 32'h0,  32'h1001, 32'h0,   32'h0,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,1,1,32'h1000, 1,16'd3);
    add(0,0,0,0,0, 32'h0,  32'h1001, 32'h0,   32'h0,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     0,0,0,32'h0,    0,16'd3);
    // Instruction write to mtvec alongside ECALL detection, then held through the sequence
    add(0,1,1,0,0, 32'h500,32'h203,  32'h0,   32'h88,   1,12'h305,32'h777, 1,1,12'h305,32'h777,1,0,0,32'h0,  0,16'd3);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h88,   1,12'h305,32'h777, 0,1,12'h341,32'h500,1,0,0,32'h0,  1,16'd4);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h88,   1,12'h305,32'h777, 0,1,12'h342,32'd11, 1,0,0,32'h0,  1,16'd4);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h88,   1,12'h305,32'h777, 0,1,12'h300,32'h1880,1,0,0,32'h0, 1,16'd4);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h88,   1,12'h305,32'h777, 0,0,12'h0,32'h0,     1,1,1,32'h200,1,16'd4);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h88,   1,12'h305,32'h777, 1,1,12'h305,32'h777, 0,0,0,32'h0,  0,16'd4);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h88,   0,12'h0,32'h0,     0,0,12'h0,32'h0,     0,0,0,32'h0,  0,16'd4);
    // Reset while in MSTAT_T: nothing written, no redirect, everything clear afterwards
    add(0,1,1,0,0, 32'h600,32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,0,0,32'h0,    0,16'd4);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,1,12'h341,32'h600, 1,0,0,32'h0,    1,16'd5);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,1,12'h342,32'd11,  1,0,0,32'h0,    1,16'd5);
    add(1,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     1,0,0,32'h0,    1,16'd5);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     0,0,0,32'h0,    0,16'd0);
    add(0,0,0,0,0, 32'h0,  32'h203,  32'h0,   32'h8,    0,12'h0,32'h0,  0,0,12'h0,32'h0,     0,0,0,32'h0,    0,16'd0);

    foreach (vecs[i]) begin
      @(negedge clk);
      rst = vecs[i].rst; valid = vecs[i].valid; ecall = vecs[i].ecall;
      ebreak = vecs[i].ebreak; mret = vecs[i].mret; pc = vecs[i].pc;
      mtvec = vecs[i].mtvec; mepc = vecs[i].mepc; mstatus = vecs[i].mstatus;
      req = vecs[i].req; waddr = vecs[i].waddr; wdata = vecs[i].wdata;
      #1;
      got  = {gnt, we, caddr, cdata, stall, flush, rv, rpc, busy, cnt};
      want = {vecs[i].e_gnt, vecs[i].e_we, vecs[i].e_waddr, vecs[i].e_wdata,
              vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_rv, vecs[i].e_rpc,
              vecs[i].e_busy, vecs[i].e_cnt};
      applied++;
      if (got !== want) begin
        miscompares++;
        $display("FAIL vec%0d: got gnt=%b we=%b wa=%h wd=%h st=%b fl=%b rv=%b rpc=%h busy=%b cnt=%h want gnt=%b we=%b wa=%h wd=%h st=%b fl=%b rv=%b rpc=%h busy=%b cnt=%h",
                 i, gnt, we, caddr, cdata, stall, flush, rv, rpc, busy, cnt,
                 vecs[i].e_gnt, vecs[i].e_we, vecs[i].e_waddr, vecs[i].e_wdata,
                 vecs[i].e_stall, vecs[i].e_flush, vecs[i].e_rv, vecs[i].e_rpc,
                 vecs[i].e_busy, vecs[i].e_cnt);
      end
    end

    // Counter saturation: preset one below the limit, then take two traps
    @(negedge clk);
    idle_inputs();
    force dut.trap_cnt = 16'hFFFE;
    @(posedge clk);
    @(negedge clk);
    release dut.trap_cnt;
    #1;
    check("cnt_preset", {16'd0, cnt}, 32'h0000_FFFE);
    run_trap(16'hFFFF, "sat_first");
    run_trap(16'hFFFF, "sat_hold");

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

`default_nettype wire
